muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit: single-cycle multiply stage,
// radix-2 restoring divider, valid/ready handshake on both sides.
module muldiv_unit #(
  parameter int unsigned XLEN      = 32,
  parameter bit          SIGN_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            fin_q, fin_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic [XLEN-1:0] result_q, result_d;

  // Request decode, evaluated on the raw inputs for the accept edge.
  logic            in_signed_div, a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, fast_res;

  always_comb begin
    in_signed_div = op[2] & ~op[0];
    a_neg         = in_signed_div & a[XLEN-1];
    b_neg         = in_signed_div & b[XLEN-1];
    a_mag         = a_neg ? -a : a;
    b_mag         = b_neg ? -b : b;
    b_zero        = (b == '0);
    ovf           = in_signed_div & (a == MinNeg) & (b == '1);
    special       = b_zero | ovf;
    if (op[1]) fast_res = b_zero ? a : '0;
    else       fast_res = b_zero ? '1 : a;
  end

  // Multiply: operands live in quo_q (a) and dvs_q (b) while in StMul.
  logic                mul_sa, mul_sb;
  logic [2*XLEN-1:0]   mul_a_ext, mul_b_ext, prod;
  logic [XLEN-1:0]     mul_res;

  always_comb begin
    mul_sa    = (op_q == 3'd1) || (op_q == 3'd2);
    mul_sb    = (op_q == 3'd1);
    mul_a_ext = {{XLEN{mul_sa & quo_q[XLEN-1]}}, quo_q};
    mul_b_ext = {{XLEN{mul_sb & dvs_q[XLEN-1]}}, dvs_q};
    prod      = mul_a_ext * mul_b_ext;
    mul_res   = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  // One restoring step; diff[XLEN] is the borrow (shifted < divisor).
  logic [XLEN:0]   shifted, diff;
  logic            ge;
  logic [XLEN-1:0] q_fin, r_fin;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = ~diff[XLEN];
    q_fin   = qneg_q ? -quo_q : quo_q;
    r_fin   = rneg_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    fin_d    = fin_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          op_d = op;
          if (!op[2]) begin
            quo_d   = a;
            dvs_d   = b;
            state_d = StMul;
          end else if (special && SIGN_FAST) begin
            result_d = fast_res;
            state_d  = StDone;
          end else begin
            rem_d   = '0;
            quo_d   = a_mag;
            dvs_d   = b_mag;
            cnt_d   = CW'(XLEN - 1);
            fin_d   = 1'b0;
            // Divide-by-zero keeps the all-ones quotient unsigned.
            qneg_d  = (a_neg ^ b_neg) & ~b_zero;
            rneg_d  = a_neg;
            state_d = StDiv;
          end
        end
      end
      StMul: begin
        result_d = mul_res;
        state_d  = StDone;
      end
      StDiv: begin
        if (fin_q) begin
          result_d = op_q[1] ? r_fin : q_fin;
          fin_d    = 1'b0;
          state_d  = StDone;
        end else begin
          rem_d = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], ge};
          if (cnt_q == '0) fin_d = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (flush) begin
      state_d  = StIdle;
      fin_d    = 1'b0;
      cnt_d    = '0;
      result_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      fin_q    <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      fin_q    <= fin_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign result    = result_q;

endmodule
